// File: rtl/strided_buffer_writer_pkg.sv
// Shared shape-word layout and sweep state encoding for the strided buffer writer/reader pair.
package strided_buffer_writer_pkg;

    localparam int SHAPE_W = 25;
    localparam int W_LSB   = 0;
    localparam int W_BITS  = 9;
    localparam int H_LSB   = 9;
    localparam int H_BITS  = 9;
    localparam int C_LSB   = 18;
    localparam int C_BITS  = 7;

    typedef struct packed {
        logic [C_BITS-1:0] n_wrap_c;
        logic [H_BITS-1:0] h_ftm;
        logic [W_BITS-1:0] w_ftm;
    } shape_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic shape_t unpack_shape(input logic [SHAPE_W-1:0] raw);
        shape_t s;
        s.w_ftm    = raw[W_LSB +: W_BITS];
        s.h_ftm    = raw[H_LSB +: H_BITS];
        s.n_wrap_c = raw[C_LSB +: C_BITS];
        return s;
    endfunction

    function automatic logic shape_ok(input shape_t s);
        return (s.w_ftm != '0) && (s.h_ftm != '0) && (s.n_wrap_c != '0);
    endfunction

endpackage

// File: rtl/strided_buffer_writer_coord.sv
// Feature-map coordinate counter: dc innermost, then y, then x as bank remainder/quotient.
// Latency: counters step on the cycle after adv; col_end/last are combinational on current coords.
// Backpressure: none of its own; advances only when the parent accepts a word.
module ftm_coord_counter
    import strided_buffer_writer_pkg::*;
#(
    parameter int N_BUF_X = 10,
    parameter int X_REM_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               adv,
    input  shape_t             shape,
    output logic [X_REM_W-1:0] x_rem,
    output logic               col_end,
    output logic               last
);

    localparam int XP_W = W_BITS + X_REM_W + 1;
    localparam logic [X_REM_W-1:0] REM_MAX = X_REM_W'(N_BUF_X - 1);

    logic [C_BITS-1:0] dc;
    logic [H_BITS-1:0] y;
    logic [W_BITS-1:0] x_quo;
    logic              dc_end;
    logic              y_end;
    logic [XP_W-1:0]   x_pos;

    assign dc_end  = (dc == shape.n_wrap_c - C_BITS'(1));
    assign y_end   = (y == shape.h_ftm - H_BITS'(1));
    assign col_end = dc_end && y_end;
    // Constant-factor recombination of x, only used for the final-word flag.
    assign x_pos   = XP_W'(x_quo) * XP_W'(N_BUF_X) + XP_W'(x_rem);
    assign last    = col_end && (x_pos == XP_W'(shape.w_ftm) - XP_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc    <= '0;
            y     <= '0;
            x_rem <= '0;
            x_quo <= '0;
        end else if (clr) begin
            dc    <= '0;
            y     <= '0;
            x_rem <= '0;
            x_quo <= '0;
        end else if (adv) begin
            if (dc_end) begin
                dc <= '0;
                if (y_end) begin
                    y <= '0;
                    if (x_rem == REM_MAX) begin
                        x_rem <= '0;
                        x_quo <= x_quo + W_BITS'(1);
                    end else begin
                        x_rem <= x_rem + X_REM_W'(1);
                    end
                end else begin
                    y <= y + H_BITS'(1);
                end
            end else begin
                dc <= dc + C_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/strided_buffer_writer.sv
// Scatters a streamed feature map across x-interleaved buffer banks (bank = x mod N_BUF_X).
// Latency: bank write appears one cycle after the stream handshake; done with the final write.
// Backpressure: s_tready is high for the whole sweep, so the stream is never stalled mid-sweep.
module strided_buffer_writer
    import strided_buffer_writer_pkg::*;
#(
    parameter int N_BUF_X    = 10,
    parameter int B_BUF_ADDR = 9,
    parameter int B_SHAPE    = 25,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [B_SHAPE-1:0]            ftm_shape,
    input  logic [DATA_WIDTH-1:0]         s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          s_tlast,
    output logic [N_BUF_X-1:0]            wr_en,
    output logic [B_BUF_ADDR*N_BUF_X-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          tog
);

    localparam int X_REM_W = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;
    localparam int OFF_W   = C_BITS + H_BITS;
    localparam int FULL_W  = OFF_W + W_BITS;
    localparam logic [X_REM_W-1:0] REM_MAX = X_REM_W'(N_BUF_X - 1);

    state_t                        state_q;
    state_t                        state_d;
    shape_t                        shape_q;
    shape_t                        shape_in;
    logic                          start_ok;
    logic                          start_bad;
    logic                          hs;
    logic                          word_end;
    logic [X_REM_W-1:0]            x_rem;
    logic                          col_end;
    logic                          last_word;
    logic [OFF_W-1:0]              col_off;
    logic [FULL_W-1:0]             col_base;
    logic [FULL_W-1:0]             addr_full;
    logic                          in_range;
    logic [N_BUF_X-1:0]            wr_en_d;
    logic [B_BUF_ADDR*N_BUF_X-1:0] wr_addr_d;

    assign shape_in  = unpack_shape(ftm_shape[SHAPE_W-1:0]);
    assign start_ok  = start && (state_q == ST_IDLE) && shape_ok(shape_in);
    assign start_bad = start && (state_q == ST_IDLE) && !shape_ok(shape_in);
    assign hs        = s_tvalid && s_tready;
    assign word_end  = hs && (last_word || s_tlast);
    assign addr_full = col_base + FULL_W'(col_off);
    assign in_range  = ((addr_full >> B_BUF_ADDR) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_WRITE;
            ST_WRITE: if (word_end) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_tready = (state_q == ST_WRITE);
        busy     = (state_q == ST_WRITE);
        done     = (state_q == ST_DONE);
    end

    ftm_coord_counter #(
        .N_BUF_X (N_BUF_X),
        .X_REM_W (X_REM_W)
    ) u_coord (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .adv     (hs),
        .shape   (shape_q),
        .x_rem   (x_rem),
        .col_end (col_end),
        .last    (last_word)
    );

    // Bank address = col_base + col_off; col_base jumps by one column's word count
    // each time x wraps back to bank 0, which replaces the n*(y + h*x_quo) product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shape_q  <= '0;
            col_off  <= '0;
            col_base <= '0;
        end else if (start_ok) begin
            shape_q  <= shape_in;
            col_off  <= '0;
            col_base <= '0;
        end else if (hs) begin
            if (col_end) begin
                col_off <= '0;
                if (x_rem == REM_MAX) begin
                    col_base <= col_base + FULL_W'(col_off) + FULL_W'(1);
                end
            end else begin
                col_off <= col_off + OFF_W'(1);
            end
        end
    end

    always_comb begin
        wr_en_d   = '0;
        wr_addr_d = '0;
        if (hs && in_range) begin
            wr_en_d[x_rem] = 1'b1;
            wr_addr_d[x_rem*B_BUF_ADDR +: B_BUF_ADDR] = addr_full[B_BUF_ADDR-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            err     <= 1'b0;
            tog     <= 1'b0;
        end else begin
            wr_en   <= wr_en_d;
            wr_addr <= wr_addr_d;
            if (hs) begin
                wr_data <= s_tdata;
            end
            if (start_ok) begin
                err <= 1'b0;
            end else if (start_bad) begin
                err <= 1'b1;
            end else if (hs && (!in_range || (s_tlast != last_word))) begin
                err <= 1'b1;
            end
            if (word_end) begin
                tog <= ~tog;
            end
        end
    end

endmodule

// File: tb/tb_strided_buffer_writer.sv
// Directed bench for strided_buffer_writer: table of sweeps plus reset and bad-shape sequences.
module tb_strided_buffer_writer;

    localparam int NB = 10;
    localparam int BA = 9;
    localparam int BS = 25;
    localparam int DW = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [BS-1:0]    ftm_shape;
    logic [DW-1:0]    s_tdata;
    logic             s_tvalid;
    logic             s_tready;
    logic             s_tlast;
    logic [NB-1:0]    wr_en;
    logic [BA*NB-1:0] wr_addr;
    logic [DW-1:0]    wr_data;
    logic             busy;
    logic             done;
    logic             err;
    logic             tog;

    always #5 clk = ~clk;

    strided_buffer_writer #(
        .N_BUF_X    (NB),
        .B_BUF_ADDR (BA),
        .B_SHAPE    (BS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ftm_shape (ftm_shape),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tog       (tog)
    );

    typedef struct {
        int w;
        int h;
        int n;
        bit vtog;
        int tlast_at;
        int exp_wr;
        bit exp_err;
        int cb;
        int ca;
        int cw;
    } vec_t;

    vec_t          vecs [9];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            nwr;
    int            ndone;
    bit            bad_hot;
    bit            bad_slice;
    logic [DW-1:0] mem [NB][512];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dword(input int tag, input int k);
        return {16'hC0DE, tag[15:0], k[31:0]};
    endfunction

    task automatic tick();
        @(negedge clk);
        if (wr_en != '0) begin
            nwr++;
            if ($countones(wr_en) != 1) bad_hot = 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            if (wr_en[b]) mem[b][wr_addr[b*BA +: BA]] = wr_data;
            else if (wr_addr[b*BA +: BA] != '0) bad_slice = 1'b1;
        end
        if (done) ndone++;
    endtask

    // tlast_at < 0 marks the final word; stop_at cuts the stream short.
    task automatic run_sweep(input int w, input int h, input int n, input bit vtog,
                             input int tlast_at, input int stop_at, input int tag);
        int total;
        int tl;
        int limit;
        int k;
        int guard;
        bit phase;
        total = w * h * n;
        tl    = (tlast_at < 0) ? total - 1 : tlast_at;
        limit = total;
        if (stop_at < limit) limit = stop_at;
        if (tl + 1 < limit) limit = tl + 1;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 512; a++) mem[b][a] = '1;
        nwr = 0; ndone = 0; bad_hot = 1'b0; bad_slice = 1'b0;
        ftm_shape = {n[6:0], h[8:0], w[8:0]};
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0; phase = 1'b0; guard = 0;
        while (k < limit && guard < 4 * total + 50) begin
            if (s_tready && (!vtog || phase)) begin
                s_tvalid = 1'b1;
                s_tdata  = dword(tag, k);
                s_tlast  = (k == tl);
                k++;
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
            phase = !phase;
            guard++;
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (k < limit) chk("sweep_timeout", k, limit);
        repeat (3) tick();
    endtask

    initial begin
        logic tog0;
        logic t_exp;
        vecs[0] = '{3, 2, 1, 1'b0, -1, 6, 1'b0, 0, 1, 1};
        vecs[1] = '{3, 2, 1, 1'b0, -1, 6, 1'b0, 2, 1, 5};
        vecs[2] = '{12, 2, 2, 1'b0, -1, 48, 1'b0, 0, 4, 40};
        vecs[3] = '{12, 2, 2, 1'b0, -1, 48, 1'b0, 1, 7, 47};
        vecs[4] = '{12, 2, 2, 1'b0, -1, 48, 1'b0, 9, 3, 39};
        vecs[5] = '{3, 2, 1, 1'b1, -1, 6, 1'b0, 1, 0, 2};
        vecs[6] = '{3, 2, 1, 1'b0, 2, 3, 1'b1, 1, 0, 2};
        vecs[7] = '{3, 2, 1, 1'b0, 9999, 6, 1'b1, 2, 0, 4};
        vecs[8] = '{1, 300, 2, 1'b0, -1, 512, 1'b1, 0, 511, 511};

        rst = 1'b1; start = 1'b0; ftm_shape = '0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        nwr = 0; ndone = 0; bad_hot = 1'b0; bad_slice = 1'b0;
        tick();
        chk("reset_outputs_zero", (wr_en == '0 && wr_addr == '0 && wr_data == '0 && !s_tready
            && !busy && !done && !err && !tog), 1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            tog0 = tog;
            run_sweep(vecs[i].w, vecs[i].h, vecs[i].n, vecs[i].vtog, vecs[i].tlast_at, 9999, i);
            t_exp = !tog0;
            chk($sformatf("v%0d_writes", i), nwr, vecs[i].exp_wr);
            chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
            chk($sformatf("v%0d_done_pulses", i), ndone, 1);
            chk($sformatf("v%0d_tog", i), tog, t_exp);
            chk($sformatf("v%0d_bank%0d_addr%0d", i, vecs[i].cb, vecs[i].ca),
                mem[vecs[i].cb][vecs[i].ca], dword(i, vecs[i].cw));
            chk($sformatf("v%0d_onehot_slices", i), bad_hot | bad_slice, 0);
        end

        // Full contents of the 3x2x1 map: bank x, address y.
        run_sweep(3, 2, 1, 1'b0, -1, 9999, 20);
        for (int x = 0; x < 3; x++)
            for (int y = 0; y < 2; y++)
                chk($sformatf("full_bank%0d_addr%0d", x, y), mem[x][y], dword(20, x * 2 + y));

        // Zero height: rejected, flagged, stays idle.
        ftm_shape = {7'd1, 9'd0, 9'd3};
        start = 1'b1;
        tick();
        start = 1'b0;
        nwr = 0;
        s_tvalid = 1'b1;
        s_tdata  = dword(21, 0);
        repeat (3) tick();
        s_tvalid = 1'b0;
        chk("zero_h_err", err, 1);
        chk("zero_h_tready", s_tready, 0);
        chk("zero_h_busy", busy, 0);
        chk("zero_h_writes", nwr, 0);

        // Reset mid-sweep after three words.
        run_sweep(3, 2, 1, 1'b0, -1, 3, 30);
        chk("mid_pre_writes", nwr, 3);
        #2 rst = 1'b1;
        #1;
        chk("mid_reset_outputs_zero", (wr_en == '0 && wr_addr == '0 && !s_tready
            && !busy && !done && !err && !tog), 1);
        chk("mid_reset_wr_data", wr_data, 0);
        tick();
        rst = 1'b0;
        nwr = 0;
        s_tvalid = 1'b1;
        s_tdata  = dword(31, 0);
        repeat (4) tick();
        s_tvalid = 1'b0;
        chk("post_reset_no_write", nwr, 0);
        chk("post_reset_tready", s_tready, 0);
        run_sweep(3, 2, 1, 1'b0, -1, 9999, 32);
        chk("restart_bank0_addr0", mem[0][0], dword(32, 0));
        chk("restart_writes", nwr, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
